// File: rtl/reg_file_ctrl_pkg.sv
// reg_file_ctrl_pkg
//   Shared definitions for the register-file initiator controller:
//   default register-file geometry, the CMD_OP encoding and the FSM state
//   encoding used by reg_file_ctrl.
//   Build option: REG_FILE_CTRL_DUMP_EN (defined -> DUMP command built in).
package reg_file_ctrl_pkg;

    localparam int unsigned RF_DATA_W   = 8;
    localparam int unsigned RF_ADDR_W   = 3;
    localparam int unsigned RF_NUM_REGS = 8;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ2 = 2'b10,
        OP_DUMP  = 2'b11
    } cmd_op_t;

    // State encoding kept as plain constants so legacy code comparing raw
    // state values continues to work.
    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_WR        = 3'd1;
    localparam state_t S_RWAIT     = 3'd2;
    localparam state_t S_RESP      = 3'd3;
    localparam state_t S_DUMP_NEXT = 3'd4;

endpackage

// File: rtl/reg_file_rd_timer.sv
// reg_file_rd_timer
//   Loadable down-counter that times the register-file read latency.
//   Ports:
//     clk_i       rising-edge clock
//     rst_i       synchronous active-high reset
//     load_i      load load_val_i (takes priority over counting)
//     load_val_i  latency to wait, 1..2**CNT_W-1
//     done_o      high in the last cycle of the wait (count == 1), i.e. the
//                 cycle in which the read data is to be sampled
module reg_file_rd_timer #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl
//   Initiator-side controller for the 8x8 register file. Accepts commands
//   (NOP / WRITE / READ2 / DUMP) on a valid/ready handshake, drives the
//   register file write port and both read-address ports, waits RD_LAT
//   cycles and returns read data on a second valid/ready handshake.
//   Ports:
//     CLK, RESET                       clock, synchronous active-high reset
//     CMD_VALID/CMD_READY/CMD_OP       command handshake and opcode
//     CMD_WADDR/CMD_WDATA              write address / data
//     CMD_RADDR1/CMD_RADDR2            read addresses
//     RF_IN/RF_INADDRESS/RF_WRITE      register file write port
//     RF_OUT1ADDRESS/RF_OUT2ADDRESS    register file read addresses
//     RF_OUT1/RF_OUT2                  register file read data
//     RSP_VALID/RSP_READY              response handshake
//     RSP_DATA1/RSP_DATA2/RSP_ADDR     response data and RSP_DATA1 address
//     RSP_LAST                         final response of a command
//   Build option: REG_FILE_CTRL_DUMP_EN -- when defined, op 11 reads all
//   registers as four pairs; otherwise op 11 is a NOP.
module reg_file_ctrl
    import reg_file_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_OP,
    input  logic [ADDR_W-1:0] CMD_WADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    input  logic [ADDR_W-1:0] CMD_RADDR1,
    input  logic [ADDR_W-1:0] CMD_RADDR2,
    output logic [DATA_W-1:0] RF_IN,
    output logic [ADDR_W-1:0] RF_INADDRESS,
    output logic              RF_WRITE,
    output logic [ADDR_W-1:0] RF_OUT1ADDRESS,
    output logic [ADDR_W-1:0] RF_OUT2ADDRESS,
    input  logic [DATA_W-1:0] RF_OUT1,
    input  logic [DATA_W-1:0] RF_OUT2,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA1,
    output logic [DATA_W-1:0] RSP_DATA2,
    output logic [ADDR_W-1:0] RSP_ADDR,
    output logic              RSP_LAST
);

    localparam int unsigned LAT_W = 3;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rf_in_q, rf_in_d;
    logic [ADDR_W-1:0] rf_inaddr_q, rf_inaddr_d;
    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rd_addr1_q, rd_addr1_d;
    logic [ADDR_W-1:0] rd_addr2_q, rd_addr2_d;
    logic [DATA_W-1:0] rsp_data1_q, rsp_data1_d;
    logic [DATA_W-1:0] rsp_data2_q, rsp_data2_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic              rsp_last_q, rsp_last_d;
`ifdef REG_FILE_CTRL_DUMP_EN
    logic              dump_q, dump_d;
    logic [1:0]        pair_q, pair_d;
`endif

    logic timer_load;
    logic timer_done;
    logic cmd_ready;

    reg_file_rd_timer #(
        .CNT_W (LAT_W)
    ) u_rd_timer (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .load_i     (timer_load),
        .load_val_i (LAT_W'(RD_LAT)),
        .done_o     (timer_done)
    );

    assign cmd_ready = (state_q == S_IDLE) && !RESET;

    always_comb begin
        state_d     = state_q;
        rf_in_d     = rf_in_q;
        rf_inaddr_d = rf_inaddr_q;
        rf_write_d  = rf_write_q;
        rd_addr1_d  = rd_addr1_q;
        rd_addr2_d  = rd_addr2_q;
        rsp_data1_d = rsp_data1_q;
        rsp_data2_d = rsp_data2_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_last_d  = rsp_last_q;
`ifdef REG_FILE_CTRL_DUMP_EN
        dump_d      = dump_q;
        pair_d      = pair_q;
`endif
        timer_load  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID && cmd_ready) begin
                    case (cmd_op_t'(CMD_OP))
                        OP_WRITE: begin
                            rf_in_d     = CMD_WDATA;
                            rf_inaddr_d = CMD_WADDR;
                            rf_write_d  = 1'b1;
                            state_d     = S_WR;
                        end
                        OP_READ2: begin
                            rd_addr1_d = CMD_RADDR1;
                            rd_addr2_d = CMD_RADDR2;
                            timer_load = 1'b1;
                            state_d    = S_RWAIT;
`ifdef REG_FILE_CTRL_DUMP_EN
                            dump_d     = 1'b0;
`endif
                        end
`ifdef REG_FILE_CTRL_DUMP_EN
                        OP_DUMP: begin
                            rd_addr1_d = ADDR_W'(0);
                            rd_addr2_d = ADDR_W'(1);
                            pair_d     = 2'd0;
                            dump_d     = 1'b1;
                            timer_load = 1'b1;
                            state_d    = S_RWAIT;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_WR: begin
                rf_write_d = 1'b0;
                state_d    = S_IDLE;
            end
            // DUMP_NEXT is the first wait cycle of a follow-on dump pair; it
            // times out exactly like RWAIT.
            S_RWAIT, S_DUMP_NEXT: begin
                if (timer_done) begin
                    rsp_data1_d = RF_OUT1;
                    rsp_data2_d = RF_OUT2;
                    rsp_addr_d  = rd_addr1_q;
                    rsp_last_d  = 1'b1;
`ifdef REG_FILE_CTRL_DUMP_EN
                    if (dump_q) begin
                        rsp_last_d = (pair_q == 2'd3);
                    end
`endif
                    state_d = S_RESP;
                end else begin
                    state_d = S_RWAIT;
                end
            end
            S_RESP: begin
                if (RSP_READY) begin
                    state_d = S_IDLE;
`ifdef REG_FILE_CTRL_DUMP_EN
                    // Next pair's addresses are registered at the handshake
                    // edge so they are on the bus in the following cycle.
                    if (dump_q && !rsp_last_q) begin
                        pair_d     = pair_q + 2'd1;
                        rd_addr1_d = ADDR_W'({pair_d, 1'b0});
                        rd_addr2_d = ADDR_W'({pair_d, 1'b1});
                        timer_load = 1'b1;
                        state_d    = S_DUMP_NEXT;
                    end else begin
                        dump_d = 1'b0;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            rf_in_q     <= '0;
            rf_inaddr_q <= '0;
            rf_write_q  <= 1'b0;
            rd_addr1_q  <= '0;
            rd_addr2_q  <= '0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
            rsp_addr_q  <= '0;
            rsp_last_q  <= 1'b0;
`ifdef REG_FILE_CTRL_DUMP_EN
            dump_q      <= 1'b0;
            pair_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rf_in_q     <= rf_in_d;
            rf_inaddr_q <= rf_inaddr_d;
            rf_write_q  <= rf_write_d;
            rd_addr1_q  <= rd_addr1_d;
            rd_addr2_q  <= rd_addr2_d;
            rsp_data1_q <= rsp_data1_d;
            rsp_data2_q <= rsp_data2_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_last_q  <= rsp_last_d;
`ifdef REG_FILE_CTRL_DUMP_EN
            dump_q      <= dump_d;
            pair_q      <= pair_d;
`endif
        end
    end

    assign CMD_READY      = cmd_ready;
    assign RF_IN          = rf_in_q;
    assign RF_INADDRESS   = rf_inaddr_q;
    assign RF_WRITE       = rf_write_q;
    assign RF_OUT1ADDRESS = rd_addr1_q;
    assign RF_OUT2ADDRESS = rd_addr2_q;
    assign RSP_VALID      = (state_q == S_RESP);
    assign RSP_DATA1      = rsp_data1_q;
    assign RSP_DATA2      = rsp_data2_q;
    assign RSP_ADDR       = rsp_addr_q;
    assign RSP_LAST       = rsp_last_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb_reg_file_ctrl
//   Directed bench for reg_file_ctrl. Instance dut uses RD_LAT=1 with a
//   combinational-read register file model; instance dut3 uses RD_LAT=3
//   with a model whose read data appears two cycles after the address.
//   Build option: REG_FILE_CTRL_DUMP_EN selects the dump or op-11-as-NOP tests.
module tb_reg_file_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         n_total = 0;
    int         n_pass = 0;

    // RD_LAT = 1 instance
    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_last, rf_write;
    logic [1:0] cmd_op;
    logic [2:0] cmd_waddr, cmd_raddr1, cmd_raddr2, rf_inaddr, rf_o1a, rf_o2a, rsp_addr;
    logic [7:0] cmd_wdata, rf_in, rf_out1, rf_out2, rsp_d1, rsp_d2;
    logic [7:0] mem [8];

    // RD_LAT = 3 instance
    logic       cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_last3, rf_write3;
    logic [1:0] cmd_op3;
    logic [2:0] cmd_waddr3, cmd_raddr13, cmd_raddr23, rf_inaddr3, rf_o1a3, rf_o2a3, rsp_addr3;
    logic [7:0] cmd_wdata3, rf_in3, rf_out13, rf_out23, rsp_d13, rsp_d23;
    logic [7:0] mem3 [8];
    logic [2:0] a1_p1, a1_p2, a2_p1, a2_p2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_file_ctrl #(.DATA_W(8), .ADDR_W(3), .RD_LAT(1)) dut (
        .CLK(clk), .RESET(rst),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op),
        .CMD_WADDR(cmd_waddr), .CMD_WDATA(cmd_wdata),
        .CMD_RADDR1(cmd_raddr1), .CMD_RADDR2(cmd_raddr2),
        .RF_IN(rf_in), .RF_INADDRESS(rf_inaddr), .RF_WRITE(rf_write),
        .RF_OUT1ADDRESS(rf_o1a), .RF_OUT2ADDRESS(rf_o2a),
        .RF_OUT1(rf_out1), .RF_OUT2(rf_out2),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
        .RSP_DATA1(rsp_d1), .RSP_DATA2(rsp_d2),
        .RSP_ADDR(rsp_addr), .RSP_LAST(rsp_last)
    );

    reg_file_ctrl #(.DATA_W(8), .ADDR_W(3), .RD_LAT(3)) dut3 (
        .CLK(clk), .RESET(rst),
        .CMD_VALID(cmd_valid3), .CMD_READY(cmd_ready3), .CMD_OP(cmd_op3),
        .CMD_WADDR(cmd_waddr3), .CMD_WDATA(cmd_wdata3),
        .CMD_RADDR1(cmd_raddr13), .CMD_RADDR2(cmd_raddr23),
        .RF_IN(rf_in3), .RF_INADDRESS(rf_inaddr3), .RF_WRITE(rf_write3),
        .RF_OUT1ADDRESS(rf_o1a3), .RF_OUT2ADDRESS(rf_o2a3),
        .RF_OUT1(rf_out13), .RF_OUT2(rf_out23),
        .RSP_VALID(rsp_valid3), .RSP_READY(rsp_ready3),
        .RSP_DATA1(rsp_d13), .RSP_DATA2(rsp_d23),
        .RSP_ADDR(rsp_addr3), .RSP_LAST(rsp_last3)
    );

    // Register file models
    always @(posedge clk) begin
        if (rf_write) mem[rf_inaddr] <= rf_in;
        if (rf_write3) mem3[rf_inaddr3] <= rf_in3;
        a1_p1 <= rf_o1a3;
        a1_p2 <= a1_p1;
        a2_p1 <= rf_o2a3;
        a2_p2 <= a2_p1;
    end
    assign rf_out1  = mem[rf_o1a];
    assign rf_out2  = mem[rf_o2a];
    assign rf_out13 = mem3[a1_p2];
    assign rf_out23 = mem3[a2_p2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Presents one command, checks it is accepted, returns in cycle N+1.
    task automatic issue(input logic [1:0] op, input logic [2:0] wa, input logic [7:0] wd,
                         input logic [2:0] r1, input logic [2:0] r2);
        cmd_op = op; cmd_waddr = wa; cmd_wdata = wd;
        cmd_raddr1 = r1; cmd_raddr2 = r2; cmd_valid = 1'b1;
        chk("cmd_ready_at_accept", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_d1"}, 32'(rsp_d1), 0);
        chk({tag, "_rsp_d2"}, 32'(rsp_d2), 0);
        chk({tag, "_rsp_addr"}, 32'(rsp_addr), 0);
        chk({tag, "_rsp_last"}, 32'(rsp_last), 0);
        chk({tag, "_rf_write"}, 32'(rf_write), 0);
        chk({tag, "_rf_in"}, 32'(rf_in), 0);
        chk({tag, "_rf_inaddr"}, 32'(rf_inaddr), 0);
        chk({tag, "_rf_o1a"}, 32'(rf_o1a), 0);
        chk({tag, "_rf_o2a"}, 32'(rf_o2a), 0);
    endtask

    initial begin
        int k;
        int prev;
        int quiet;
        for (int i = 0; i < 8; i++) begin
            mem[i]  = 8'h00;
            mem3[i] = 8'h30 + 8'(i);
        end
        rst = 1'b1; rsp_ready = 1'b1; rsp_ready3 = 1'b1;
        // Command presented during reset must be ignored.
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_waddr = 3'd2; cmd_wdata = 8'hFF;
        cmd_raddr1 = '0; cmd_raddr2 = '0;
        cmd_valid3 = 1'b0; cmd_op3 = 2'b00; cmd_waddr3 = '0; cmd_wdata3 = '0;
        cmd_raddr13 = '0; cmd_raddr23 = '0;
        tick(); tick();
        chk("reset_cmd_ready", 32'(cmd_ready), 0);
        chk_all_zero("reset");
        rst = 1'b0; cmd_valid = 1'b0;
        #1;
        chk("post_reset_cmd_ready", 32'(cmd_ready), 1);
        tick();
        chk("post_reset_no_write", 32'(rf_write), 0);

        // RD_LAT=3: accepted in N, RSP_VALID first in N+4.
        cmd_op3 = 2'b10; cmd_raddr13 = 3'd2; cmd_raddr23 = 3'd7; cmd_valid3 = 1'b1;
        chk("lat3_accept", 32'(cmd_ready3), 1);
        tick(); cmd_valid3 = 1'b0;
        chk("lat3_n1", 32'(rsp_valid3), 0);
        tick(); chk("lat3_n2", 32'(rsp_valid3), 0);
        tick(); chk("lat3_n3", 32'(rsp_valid3), 0);
        tick();
        chk("lat3_n4_valid", 32'(rsp_valid3), 1);
        chk("lat3_d1", 32'(rsp_d13), 32'h32);
        chk("lat3_d2", 32'(rsp_d23), 32'h37);
        chk("lat3_addr", 32'(rsp_addr3), 2);
        tick();
        chk("lat3_done_valid", 32'(rsp_valid3), 0);
        chk("lat3_done_ready", 32'(cmd_ready3), 1);

        // WRITE 5 <- A7, then READ2 (5,0) with the response stalled.
        issue(2'b01, 3'd5, 8'hA7, 3'd0, 3'd0);
        chk("wr_pulse", 32'(rf_write), 1);
        chk("wr_addr", 32'(rf_inaddr), 5);
        chk("wr_data", 32'(rf_in), 32'hA7);
        chk("wr_busy", 32'(cmd_ready), 0);
        tick();
        chk("wr_pulse_end", 32'(rf_write), 0);
        chk("wr_ready_again", 32'(cmd_ready), 1);
        chk("wr_addr_hold", 32'(rf_inaddr), 5);
        rsp_ready = 1'b0;
        issue(2'b10, 3'd0, 8'h00, 3'd5, 3'd0);
        chk("rd_addr1", 32'(rf_o1a), 5);
        chk("rd_addr2", 32'(rf_o2a), 0);
        chk("rd_wait_valid", 32'(rsp_valid), 0);
        chk("rd_wait_ready", 32'(cmd_ready), 0);
        tick();
        chk("rd_valid", 32'(rsp_valid), 1);
        chk("rd_d1", 32'(rsp_d1), 32'hA7);
        chk("rd_d2", 32'(rsp_d2), 32'h00);
        chk("rd_addr", 32'(rsp_addr), 5);
        chk("rd_last", 32'(rsp_last), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(rsp_valid), 1);
            chk("stall_d1", 32'(rsp_d1), 32'hA7);
            chk("stall_d2", 32'(rsp_d2), 32'h00);
            chk("stall_ready", 32'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("hs_valid_drop", 32'(rsp_valid), 0);
        chk("hs_cmd_ready", 32'(cmd_ready), 1);
        chk("hs_addr_hold", 32'(rf_o1a), 5);

        // Fill registers 0..7 with 0x10..0x17.
        for (int i = 0; i < 8; i++) begin
            issue(2'b01, 3'(i), 8'h10 + 8'(i), 3'd0, 3'd0);
            chk("fill_addr", 32'(rf_inaddr), 32'(i));
            tick();
        end
        issue(2'b10, 3'd0, 8'h00, 3'd3, 3'd6);
        tick();
        chk("rd36_d1", 32'(rsp_d1), 32'h13);
        chk("rd36_d2", 32'(rsp_d2), 32'h16);
        chk("rd36_addr", 32'(rsp_addr), 3);
        tick();

        // NOP: no response, ready again next cycle.
        issue(2'b00, 3'd1, 8'h55, 3'd1, 3'd1);
        chk("nop_ready", 32'(cmd_ready), 1);
        chk("nop_no_rsp", 32'(rsp_valid), 0);
        chk("nop_no_write", 32'(rf_write), 0);

`ifdef REG_FILE_CTRL_DUMP_EN
        issue(2'b11, 3'd0, 8'h00, 3'd0, 3'd0);
        k = 0; prev = cyc - 1;
        for (int c = 0; c < 30 && k < 4; c++) begin
            if (rsp_valid) begin
                chk("dump_d1", 32'(rsp_d1), 32'h10 + 32'(2 * k));
                chk("dump_d2", 32'(rsp_d2), 32'h11 + 32'(2 * k));
                chk("dump_addr", 32'(rsp_addr), 32'(2 * k));
                chk("dump_last", 32'(rsp_last), (k == 3) ? 1 : 0);
                chk("dump_gap", 32'(cyc - prev), 2);
                prev = cyc; k++;
            end
            chk("dump_no_write", 32'(rf_write), 0);
            tick();
        end
        chk("dump_count", 32'(k), 4);
        quiet = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid) quiet++;
            tick();
        end
        chk("dump_quiet_after", 32'(quiet), 0);
        chk("dump_ready_after", 32'(cmd_ready), 1);
`else
        issue(2'b11, 3'd4, 8'h99, 3'd7, 3'd7);
        chk("op11_ready", 32'(cmd_ready), 1);
        chk("op11_no_write", 32'(rf_write), 0);
        chk("op11_o1a_hold", 32'(rf_o1a), 3);
        quiet = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid || rf_write) quiet++;
            tick();
        end
        chk("op11_no_rsp", 32'(quiet), 0);
`endif

        // Reset while in RWAIT, with a WRITE presented during reset.
        issue(2'b10, 3'd0, 8'h00, 3'd1, 3'd2);
        rst = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_waddr = 3'd4; cmd_wdata = 8'hEE;
        #1;
        chk("rwait_rst_ready", 32'(cmd_ready), 0);
        tick();
        chk_all_zero("rwait_rst");
        chk("rwait_rst_ready2", 32'(cmd_ready), 0);
        rst = 1'b0; cmd_valid = 1'b0;
        #1;
        chk("rwait_rel_ready", 32'(cmd_ready), 1);
        quiet = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid || rf_write) quiet++;
            tick();
        end
        chk("rwait_rst_quiet", 32'(quiet), 0);
        issue(2'b10, 3'd0, 8'h00, 3'd4, 3'd4);
        tick();
        chk("rst_write_ignored", 32'(rsp_d1), 32'h14);
        tick();

`ifdef REG_FILE_CTRL_DUMP_EN
        // Reset in RESP part-way through a dump.
        issue(2'b11, 3'd0, 8'h00, 3'd0, 3'd0);
        k = 0;
        for (int c = 0; c < 30 && k < 2; c++) begin
            if (rsp_valid) k++;
            if (k < 2) tick();
        end
        chk("middump_reached", 32'(k), 2);
        chk("middump_addr", 32'(rsp_addr), 2);
`else
        // Reset in RESP of a stalled READ2.
        rsp_ready = 1'b0;
        issue(2'b10, 3'd0, 8'h00, 3'd6, 3'd7);
        tick();
        chk("resp_rst_reached", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
`endif
        rst = 1'b1;
        #1;
        chk("resp_rst_ready", 32'(cmd_ready), 0);
        tick();
        chk_all_zero("resp_rst");
        rst = 1'b0;
        #1;
        chk("resp_rel_ready", 32'(cmd_ready), 1);
        quiet = 0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid) quiet++;
            tick();
        end
        chk("resp_rst_quiet", 32'(quiet), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
